// File: rtl/row_arb_cam.sv
// row_arb_cam: row/bank CAM counting pending packets per key, arbitrating UI vs. retry look-ups.
// Optional feature: define ROWARB_STARVE_GUARD_EN to bound how long the UI path can lose to intf.
module row_arb_cam #(
  parameter int SLOTS          = 8,
  parameter int CNT_WIDTH      = 4,
  parameter int PRIO           = 4,
  parameter int ROW_ADDR_WIDTH = 16,
  parameter int BK_ADDR_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ui_pkt_req,
  input  logic [$clog2(PRIO)-1:0]   ui_prio,
  input  logic [ROW_ADDR_WIDTH-1:0] ui_row_addr,
  input  logic [BK_ADDR_WIDTH-1:0]  ui_bk_addr,
  input  logic                      intf_pkt_req,
  input  logic [$clog2(PRIO)-1:0]   intf_prio,
  input  logic [ROW_ADDR_WIDTH-1:0] intf_row_addr,
  input  logic [BK_ADDR_WIDTH-1:0]  intf_bk_addr,
  output logic                      ui_pkt_ack,
  output logic                      intf_pkt_ack,
  output logic [$clog2(SLOTS)-1:0]  ack_slot,
  output logic                      ack_hit,
  input  logic                      rel_valid,
  input  logic [$clog2(SLOTS)-1:0]  rel_slot,
  output logic [SLOTS-1:0]          slot_valid,
  output logic                      cam_full,
  output logic                      rel_err
);

  localparam int PW = $clog2(PRIO);
  localparam int SW = $clog2(SLOTS);
  localparam int KW = PW + BK_ADDR_WIDTH + ROW_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [SLOTS-1:0]     slotValid_q, slotValid_d;
  logic [KW-1:0]        key_q [SLOTS];
  logic [KW-1:0]        key_d [SLOTS];
  logic [CNT_WIDTH-1:0] cnt_q [SLOTS];
  logic [CNT_WIDTH-1:0] cnt_d [SLOTS];
  logic                 relErr_q, relErr_d;

  logic [KW-1:0] uiKey, intfKey, grantKey;
  logic          uiHit, intfHit, anyFree;
  logic [SW-1:0] uiHitSlot, intfHitSlot, freeSlot, grantSlot;
  logic          uiElig, intfElig, uiGrant, intfGrant, anyGrant, grantHit;
  logic          relLegal, starveForceUi;
  logic [SLOTS-1:0] grantVec, relVec;

  assign uiKey   = {ui_prio, ui_bk_addr, ui_row_addr};
  assign intfKey = {intf_prio, intf_bk_addr, intf_row_addr};

  // Descending scan so the lowest matching / free index is the one left standing.
  always_comb begin
    uiHit       = 1'b0;
    intfHit     = 1'b0;
    anyFree     = 1'b0;
    uiHitSlot   = '0;
    intfHitSlot = '0;
    freeSlot    = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slotValid_q[i] && (key_q[i] == uiKey)) begin
        uiHit     = 1'b1;
        uiHitSlot = SW'(i);
      end
      if (slotValid_q[i] && (key_q[i] == intfKey)) begin
        intfHit     = 1'b1;
        intfHitSlot = SW'(i);
      end
      if (!slotValid_q[i]) begin
        anyFree  = 1'b1;
        freeSlot = SW'(i);
      end
    end
  end

  assign relLegal = rel_valid && slotValid_q[rel_slot] && (cnt_q[rel_slot] != '0);

  // A saturated slot can still take a hit when the same slot retires a packet this cycle.
  assign uiElig = ui_pkt_req &&
                  (uiHit ? ((cnt_q[uiHitSlot] != CNT_MAX) || (rel_valid && (rel_slot == uiHitSlot)))
                         : anyFree);
  assign intfElig = intf_pkt_req &&
                    (intfHit ? ((cnt_q[intfHitSlot] != CNT_MAX) || (rel_valid && (rel_slot == intfHitSlot)))
                             : anyFree);

`ifdef ROWARB_STARVE_GUARD_EN
  logic [1:0] starve_q, starve_d;

  assign starveForceUi = (starve_q == 2'd3) && intf_pkt_req && uiElig;

  always_comb begin
    starve_d = starve_q;
    if (uiGrant || !ui_pkt_req) begin
      starve_d = 2'd0;
    end else if (intfGrant && (starve_q != 2'd3)) begin
      starve_d = starve_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign starveForceUi = 1'b0;
`endif

  always_comb begin
    uiGrant   = 1'b0;
    intfGrant = 1'b0;
    if (rst_n) begin
      if (starveForceUi) begin
        uiGrant = 1'b1;
      end else if (intfElig) begin
        intfGrant = 1'b1;
      end else if (uiElig) begin
        uiGrant = 1'b1;
      end
    end
  end

  assign anyGrant  = uiGrant || intfGrant;
  assign grantHit  = intfGrant ? intfHit : (uiGrant ? uiHit : 1'b0);
  assign grantKey  = intfGrant ? intfKey : uiKey;
  assign grantSlot = intfGrant ? (intfHit ? intfHitSlot : freeSlot)
                   : uiGrant   ? (uiHit ? uiHitSlot : freeSlot)
                   : '0;

  always_comb begin
    grantVec = '0;
    relVec   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      grantVec[i] = anyGrant && (grantSlot == SW'(i));
      relVec[i]   = relLegal && (rel_slot == SW'(i));
    end
  end

  // A grant and a release landing on the same slot cancel out.
  always_comb begin
    slotValid_d = slotValid_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    relErr_d    = rel_valid && !relLegal;
    for (int i = 0; i < SLOTS; i++) begin
      if (grantVec[i] && !grantHit) begin
        slotValid_d[i] = 1'b1;
        key_d[i]       = grantKey;
        cnt_d[i]       = CNT_ONE;
      end else if (grantVec[i] && !relVec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (relVec[i] && !grantVec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
        if (cnt_q[i] == CNT_ONE) begin
          slotValid_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotValid_q <= '0;
      relErr_q    <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        key_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      slotValid_q <= slotValid_d;
      relErr_q    <= relErr_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ui_pkt_ack   = uiGrant;
  assign intf_pkt_ack = intfGrant;
  assign ack_slot     = grantSlot;
  assign ack_hit      = grantHit;
  assign slot_valid   = slotValid_q;
  assign cam_full     = rst_n && (&slotValid_q);
  assign rel_err      = relErr_q;

endmodule

// File: tb/tb_row_arb_cam.sv
// tb_row_arb_cam: directed, table-driven bench for row_arb_cam with default parameters.
// Build with ROWARB_STARVE_GUARD_EN defined to expect the UI anti-starvation grant.
module tb_row_arb_cam;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        uiReq, intfReq, relValid;
  logic [1:0]  uiPrio, intfPrio;
  logic [3:0]  uiBk, intfBk;
  logic [15:0] uiRow, intfRow;
  logic [2:0]  relSlot;
  logic        uiAck, intfAck, ackHit, camFull, relErr;
  logic [2:0]  ackSlot;
  logic [7:0]  slotValid;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  row_arb_cam dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ui_pkt_req   (uiReq),
    .ui_prio      (uiPrio),
    .ui_row_addr  (uiRow),
    .ui_bk_addr   (uiBk),
    .intf_pkt_req (intfReq),
    .intf_prio    (intfPrio),
    .intf_row_addr(intfRow),
    .intf_bk_addr (intfBk),
    .ui_pkt_ack   (uiAck),
    .intf_pkt_ack (intfAck),
    .ack_slot     (ackSlot),
    .ack_hit      (ackHit),
    .rel_valid    (relValid),
    .rel_slot     (relSlot),
    .slot_valid   (slotValid),
    .cam_full     (camFull),
    .rel_err      (relErr)
  );

  typedef struct {
    logic        uiReq;
    logic [1:0]  uiPrio;
    logic [3:0]  uiBk;
    logic [15:0] uiRow;
    logic        intfReq;
    logic [1:0]  intfPrio;
    logic [3:0]  intfBk;
    logic [15:0] intfRow;
    logic        relValid;
    logic [2:0]  relSlot;
    logic        expUiAck;
    logic        expIntfAck;
    logic [2:0]  expSlot;
    logic        expHit;
    logic [7:0]  expValid;
    logic        expFull;
    logic        expErr;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic ur, input logic [1:0] up, input logic [3:0] ub, input logic [15:0] urw,
                              input logic ir, input logic [1:0] ip, input logic [3:0] ib, input logic [15:0] irw,
                              input logic rv, input logic [2:0] rs,
                              input logic eu, input logic ei, input logic [2:0] es, input logic eh,
                              input logic [7:0] ev, input logic ef, input logic ee);
    vec_t v;
    v.uiReq = ur;   v.uiPrio = up;   v.uiBk = ub;   v.uiRow = urw;
    v.intfReq = ir; v.intfPrio = ip; v.intfBk = ib; v.intfRow = irw;
    v.relValid = rv; v.relSlot = rs;
    v.expUiAck = eu; v.expIntfAck = ei; v.expSlot = es; v.expHit = eh;
    v.expValid = ev; v.expFull = ef; v.expErr = ee;
    return v;
  endfunction

  task automatic checkField(input string tag, input string field, input logic [15:0] act, input logic [15:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s %s: got %0h, expected %0h", tag, field, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    uiReq    = v.uiReq;    uiPrio   = v.uiPrio;   uiBk   = v.uiBk;   uiRow   = v.uiRow;
    intfReq  = v.intfReq;  intfPrio = v.intfPrio; intfBk = v.intfBk; intfRow = v.intfRow;
    relValid = v.relValid; relSlot  = v.relSlot;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkField(tag, "ui_pkt_ack",   16'(uiAck),     16'(v.expUiAck));
    checkField(tag, "intf_pkt_ack", 16'(intfAck),   16'(v.expIntfAck));
    checkField(tag, "ack_slot",     16'(ackSlot),   16'(v.expSlot));
    checkField(tag, "ack_hit",      16'(ackHit),    16'(v.expHit));
    checkField(tag, "slot_valid",   16'(slotValid), 16'(v.expValid));
    checkField(tag, "cam_full",     16'(camFull),   16'(v.expFull));
    checkField(tag, "rel_err",      16'(relErr),    16'(v.expErr));
  endtask

  task automatic runCycle(input vec_t v, input string tag);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(mk(1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                     1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
  endtask

  task automatic doReset();
    idleInputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Keys: K0={0,2,0x10} KA={1,0,0x20} KB={2,1,0x30} KC={3,F,FFFF} KD={0,0,0} KE={0,0,1}
    tbl[0]  = mk(1'b1, 2'd0, 4'd2, 16'h0010, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 2'd0, 4'd2, 16'h0010, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h01, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 8'h03, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0, 8'h03, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 8'h07, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h07, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h07, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b1, 3'd1, 1'b0, 1'b1, 3'd1, 1'b1, 8'h07, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h07, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h07, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h05, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h05, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 2'd3, 4'hF, 16'hFFFF, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h05, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h07, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b1, 3'd2, 1'b1, 1'b0, 3'd3, 1'b0, 8'h07, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 2'd0, 4'd0, 16'h0001, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0, 8'h0B, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Hold a UI request through reset: nothing may be acknowledged while rst_n is low.
    idleInputs();
    uiReq = 1'b1; uiPrio = 2'd0; uiBk = 4'd2; uiRow = 16'h0010;
    #1 rst_n = 1'b0;
    #2;
    checkField("RST", "ui_pkt_ack",   16'(uiAck),     16'h0);
    checkField("RST", "intf_pkt_ack", 16'(intfAck),   16'h0);
    checkField("RST", "slot_valid",   16'(slotValid), 16'h0);
    checkField("RST", "cam_full",     16'(camFull),   16'h0);
    checkField("RST", "rel_err",      16'(relErr),    16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      runCycle(tbl[i], $sformatf("T%0d", i));
    end

    // Saturate slot 0, stall, then take the hit together with a release.
    doReset();
    for (int k = 0; k < 15; k++) begin
      runCycle(mk(1'b1, 2'd0, 4'd2, 16'h0010, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                  1'b1, 1'b0, 3'd0, (k != 0), (k == 0) ? 8'h00 : 8'h01, 1'b0, 1'b0), $sformatf("B%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      runCycle(mk(1'b1, 2'd0, 4'd2, 16'h0010, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                  1'b0, 1'b0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0), $sformatf("Bsat%0d", k));
    end
    runCycle(mk(1'b1, 2'd0, 4'd2, 16'h0010, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 3'd0,
                1'b1, 1'b0, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0), "BrelHit");
    runCycle(mk(1'b1, 2'd0, 4'd2, 16'h0010, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                1'b0, 1'b0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0), "BsatAgain");
    runCycle(mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 3'd0,
                1'b0, 1'b0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0), "BrelOnly");
    runCycle(mk(1'b1, 2'd0, 4'd2, 16'h0010, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                1'b1, 1'b0, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0), "BhitAfter");

    // Fill every slot, block a ninth key, free slot 3 and watch it get reused a cycle later.
    doReset();
    for (int i = 0; i < 8; i++) begin
      runCycle(mk(1'b1, 2'd0, 4'd0, 16'(i), 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                  1'b1, 1'b0, 3'(i), 1'b0, 8'((1 << i) - 1), 1'b0, 1'b0), $sformatf("C%0d", i));
    end
    runCycle(mk(1'b1, 2'd0, 4'd0, 16'h0008, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0), "Cfull");
    runCycle(mk(1'b1, 2'd0, 4'd0, 16'h0008, 1'b0, 2'd0, 4'd0, 16'h0, 1'b1, 3'd3,
                1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0), "CrelSame");
    runCycle(mk(1'b1, 2'd0, 4'd0, 16'h0008, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                1'b1, 1'b0, 3'd3, 1'b0, 8'hF7, 1'b0, 1'b0), "Calloc");
    runCycle(mk(1'b0, 2'd0, 4'd0, 16'h0000, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 1'b1, 1'b0), "Crefull");

    // Asynchronous reset in the middle of an acknowledged hit.
    applyStimulus(mk(1'b1, 2'd0, 4'd0, 16'h0001, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                     1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
    #2;
    checkField("Dpre", "ui_pkt_ack", 16'(uiAck),   16'h1);
    checkField("Dpre", "ack_slot",   16'(ackSlot), 16'h1);
    checkField("Dpre", "ack_hit",    16'(ackHit),  16'h1);
    rst_n = 1'b0;
    #1;
    checkField("Drst", "ui_pkt_ack",   16'(uiAck),     16'h0);
    checkField("Drst", "intf_pkt_ack", 16'(intfAck),   16'h0);
    checkField("Drst", "slot_valid",   16'(slotValid), 16'h0);
    checkField("Drst", "cam_full",     16'(camFull),   16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    runCycle(mk(1'b1, 2'd0, 4'd0, 16'h0001, 1'b0, 2'd0, 4'd0, 16'h0, 1'b0, 3'd0,
                1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0), "Dfirst");

    // Both requesters held with distinct keys.
    doReset();
    runCycle(mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b0, 3'd0,
                1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0), "E1");
    runCycle(mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b0, 3'd0,
                1'b0, 1'b1, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0), "E2");
    runCycle(mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b0, 3'd0,
                1'b0, 1'b1, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0), "E3");
`ifdef ROWARB_STARVE_GUARD_EN
    runCycle(mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b0, 3'd0,
                1'b1, 1'b0, 3'd1, 1'b0, 8'h01, 1'b0, 1'b0), "E4");
    runCycle(mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b0, 3'd0,
                1'b0, 1'b1, 3'd0, 1'b1, 8'h03, 1'b0, 1'b0), "E5");
`else
    runCycle(mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b0, 3'd0,
                1'b0, 1'b1, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0), "E4");
    runCycle(mk(1'b1, 2'd1, 4'd0, 16'h0020, 1'b1, 2'd2, 4'd1, 16'h0030, 1'b0, 3'd0,
                1'b0, 1'b1, 3'd0, 1'b1, 8'h01, 1'b0, 1'b0), "E5");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/row_arb_cam.md
ROW_ARB_CAM -- requirements
Module: row_arb_cam

Interface
REQ-001 SHALL have parameter SLOTS, default 8: number of CAM slots (power of two, >=2).
REQ-002 SHALL have parameter CNT_WIDTH, default 4: width of per-slot pending-packet counter.
REQ-003 SHALL have parameter PRIO, default 4: priority levels; key prio width is $clog2(PRIO).
REQ-004 SHALL have parameters ROW_ADDR_WIDTH, default 16, and BK_ADDR_WIDTH, default 4: key address widths.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports ui_pkt_req, intf_pkt_req  input  1 each  CAM look-up requests from UI path and Data Handler retry path.
REQ-008 SHALL have ports ui_prio/ui_row_addr/ui_bk_addr and intf_prio/intf_row_addr/intf_bk_addr  input  $clog2(PRIO)/ROW_ADDR_WIDTH/BK_ADDR_WIDTH  look-up keys.
REQ-009 SHALL have ports ui_pkt_ack, intf_pkt_ack  output  1 each  request accepted this cycle.
REQ-010 SHALL have ports ack_slot  output  $clog2(SLOTS)  slot index of accepted request; ack_hit  output  1  accepted on existing slot.
REQ-011 SHALL have ports rel_valid  input  1, rel_slot  input  $clog2(SLOTS)  one packet of rel_slot retired.
REQ-012 SHALL have ports slot_valid  output  SLOTS  per-slot occupied flags; cam_full  output  1  all slots occupied; rel_err  output  1  registered illegal-release pulse.

Function
REQ-013 Key SHALL be {prio, bk_addr, row_addr}; match requires slot_valid and exact equality of all three fields.
REQ-014 Selection SHALL be combinational: intf_pkt_req wins over ui_pkt_req; at most one ack per cycle; ack asserted in the same cycle as the winning req.
REQ-015 Hit with count < 2^CNT_WIDTH-1: ack, ack_hit=1, ack_slot=matching slot, count+1 at next edge.
REQ-016 Hit with count saturated: no ack; request stalls until a release reduces count.
REQ-017 Miss with free slot: ack, ack_hit=0, ack_slot=lowest-index free slot; next edge slot becomes valid, key stored, count=1.
REQ-018 Miss with no free slot: no ack; cam_full=1 combinationally whenever all slot_valid bits set.
REQ-019 Free-slot search SHALL use current-cycle slot_valid; a slot freed by release this cycle is allocatable only next cycle.
REQ-020 Release on valid slot: count-1 next edge; count reaching 0 clears slot_valid.
REQ-021 Release and hit on same slot same cycle: count unchanged, slot stays valid, ack still given (including when count saturated).
REQ-022 Release on invalid slot or count 0: ignored; rel_err=1 for exactly the next cycle.
REQ-023 Losing requester receives no ack and SHALL retry by holding req; no internal queuing.
REQ-024 ack_slot/ack_hit SHALL be 0 when no ack.

Reset
REQ-025 rst_n low SHALL asynchronously clear all slot_valid, keys, counts, rel_err, starvation counter.
REQ-026 While rst_n low ui_pkt_ack and intf_pkt_ack SHALL be 0 regardless of requests; cam_full=0.
REQ-027 Reset deasserting mid-request: first eligible ack in first cycle with rst_n high, treated as miss into slot 0.

Configuration
REQ-028 Macro ROWARB_STARVE_GUARD_EN defined: 2-bit counter of consecutive intf grants while ui_pkt_req was high; at 3, next cycle with both reqs grants UI (if UI eligible) and clears counter; counter clears on any UI grant.
REQ-029 Macro undefined: strict intf-over-UI priority per REQ-014; no counter logic present.

Verification
REQ-030 Reset, ui req key {0,2,0x10} -> same-cycle ui_pkt_ack, ack_slot=0, ack_hit=0; next cycle slot_valid=8'h01.
REQ-031 Repeat same key 15 times -> 14 hits acked (count=15), 16th request no ack until rel_valid slot 0, then ack same cycle as release.
REQ-032 Fill 8 distinct keys, 9th distinct key -> cam_full=1, no ack; release slot 3 (count 1) -> next cycle ack_slot=3.
REQ-033 ui and intf req same cycle, distinct keys -> intf_pkt_ack only; with ROWARB_STARVE_GUARD_EN and both held, 4th grant goes to UI.
REQ-034 rel_valid on empty slot 5 -> rel_err=1 one cycle, no state change; rst_n low mid-burst -> acks 0 immediately, slot_valid=0.
